next_hop_selector: RTL



---
 rtl/eer_rl_pkg.sv | 19 +
 rtl/q_max_compare.sv | 39 +++
 rtl/next_hop_selector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/eer_rl_pkg.sv
// Purpose : shared constants and types for the EER-RL neighbour table path
//           (neighbour memory bank and next-hop selector).
// Contents: WORD_WIDTH / MEM_DEPTH / IDX_WIDTH, Q-value type, scan FSM states.
package eer_rl_pkg;

   localparam int WORD_WIDTH = 16;   // Q-value / memory word width
   localparam int MEM_DEPTH  = 64;   // bank entries
   localparam int IDX_WIDTH  = 6;    // log2(MEM_DEPTH)

   typedef logic [WORD_WIDTH-1:0] q_value_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/q_max_compare.sv
// Purpose : registered running maximum over a stream of (index, Q-value) pairs.
// Latency : best_* / found update on the clock edge that samples valid=1.
// Backpres: none; every valid cycle is consumed.
// Ports   : clk, nrst (sync active-low), clear (restart the max), valid/index/data
//           (candidate), found/best_index/best_value (current winner).
module q_max_compare
   import eer_rl_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  clear,
   input  logic                  valid,
   input  logic [IDX_WIDTH-1:0]  index,
   input  logic [WORD_WIDTH-1:0] data,
   output logic                  found,
   output logic [IDX_WIDTH-1:0]  best_index,
   output logic [WORD_WIDTH-1:0] best_value
);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         found      <= 1'b0;
         best_index <= '0;
         best_value <= '0;
      end else if (clear) begin
         found      <= 1'b0;
         best_index <= '0;
         best_value <= '0;
      end else if (valid) begin
         found <= 1'b1;
         // Strictly greater: on ties the earlier (lower) index is kept.
         if (!found || (data > best_value)) begin
            best_index <= index;
            best_value <= data;
         end
      end
   end

endmodule

// File: rtl/next_hop_selector.sv
// Purpose : scans the first neighbor_count words of the neighbour bank and reports
//           the index/value of the largest Q-value (the EER-RL next hop).
// Latency : start at edge E0 with N>0 -> done after E0+N+2; N=0 -> done after E0+1.
// Backpres: none; start is ignored while busy and during the done pulse.
// Ports   : clk, nrst (sync active-low); start + neighbor_count request a scan;
//           mem_index drives the bank read address, mem_data is its registered output;
//           busy/done/found/best_index/best_value report status and result.
// Option  : NEXT_HOP_EXCLUDE_EN adds exclude_valid/exclude_index (sampled with start)
//           to drop one entry from the comparison without changing the read timing.
module next_hop_selector
   import eer_rl_pkg::*;
(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [IDX_WIDTH:0]    neighbor_count,
`ifdef NEXT_HOP_EXCLUDE_EN
   input  logic                  exclude_valid,
   input  logic [IDX_WIDTH-1:0]  exclude_index,
`endif
   input  logic [WORD_WIDTH-1:0] mem_data,
   output logic [IDX_WIDTH-1:0]  mem_index,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic [IDX_WIDTH-1:0]  best_index,
   output logic [WORD_WIDTH-1:0] best_value
);

   state_t               state;
   logic [IDX_WIDTH-1:0] last_index;   // final address of the sweep
   logic                 rd_vld;       // mem_data holds a scanned word this cycle
   logic [IDX_WIDTH-1:0] rd_idx;       // address that produced mem_data
   logic                 accept;
   logic                 cmp_vld;
   logic [IDX_WIDTH-1:0] count_last;

   // The done cycle is still treated as busy for start, so a new scan begins
   // no earlier than the cycle after the pulse.
   assign accept = (state == IDLE) && start && !done;

   // Any count with the top bit set is >= MEM_DEPTH, so clamp to the last entry.
   assign count_last = neighbor_count[IDX_WIDTH] ? {IDX_WIDTH{1'b1}}
                                                 : neighbor_count[IDX_WIDTH-1:0] - 1'b1;

`ifdef NEXT_HOP_EXCLUDE_EN
   logic                 excl_vld;
   logic [IDX_WIDTH-1:0] excl_idx;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         excl_vld <= 1'b0;
         excl_idx <= '0;
      end else if (accept) begin
         excl_vld <= exclude_valid;
         excl_idx <= exclude_index;
      end
   end

   // The excluded word is still read; it is only withheld from the compare.
   assign cmp_vld = rd_vld && !(excl_vld && (rd_idx == excl_idx));
`else
   assign cmp_vld = rd_vld;
`endif

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= IDLE;
         mem_index  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         last_index <= '0;
         rd_vld     <= 1'b0;
         rd_idx     <= '0;
      end else begin
         done   <= 1'b0;
         rd_vld <= 1'b0;
         rd_idx <= mem_index;
         case (state)
            IDLE: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (neighbor_count == '0) begin
                     // Nothing to read: mem_index keeps its previous value.
                     state <= DONE;
                  end else begin
                     last_index <= count_last;
                     mem_index  <= '0;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // The address presented this cycle returns on mem_data next cycle.
               rd_vld <= 1'b1;
               if (mem_index == last_index) begin
                  state <= DRAIN;
               end else begin
                  mem_index <= mem_index + 1'b1;
               end
            end
            DRAIN: begin
               // Last word is compared on this edge.
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   q_max_compare u_max (
      .clk        (clk),
      .nrst       (nrst),
      .clear      (accept),
      .valid      (cmp_vld),
      .index      (rd_idx),
      .data       (mem_data),
      .found      (found),
      .best_index (best_index),
      .best_value (best_value)
   );

endmodule
